pwm_duty_gen: RTL and testbench

- Converts the 12-bit duty/length word produced by the duty-adjust stage into a fixed-frequency, complementary, dead-time-protected gate-drive pair for the SWIPT power stage.
- Sits directly downstream of the duty-adjust stage.
- Applies new duty values glitch-free at period boundaries only.
- Emits a period-start strobe for the measurement and control logic upstream.

---
 rtl/pwm_duty_gen_if.sv | 22 ++
 rtl/pwm_duty_gen.sv | 120 ++++++++++++
 tb/tb_pwm_duty_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_gen_if.sv
// Bundle between the duty-adjust stage / controller and the PWM generator.
// master: drives enable, sync and the requested on-time, observes the gates.
// slave:  the generator itself.
interface pwm_duty_gen_if;
  logic        en;
  logic        sync;
  logic [11:0] l_adj;
  logic        pwm_hi;
  logic        pwm_lo;
  logic        period_start;
  logic [11:0] duty_act;

  modport master (
    output en, sync, l_adj,
    input  pwm_hi, pwm_lo, period_start, duty_act
  );

  modport slave (
    input  en, sync, l_adj,
    output pwm_hi, pwm_lo, period_start, duty_act
  );
endinterface

// File: rtl/pwm_duty_gen.sv
// Fixed-frequency complementary PWM with dead-time for the SWIPT power stage.
// The requested on-time is captured into a shadow register only when the
// period counter restarts, so duty changes never produce runt pulses.
// Optional build macro: SOFT_START_EN -- ramps duty_act up by SS_STEP per
// period after every enable instead of jumping straight to the target.
module pwm_duty_gen #(
  parameter int PERIOD  = 500,
  parameter int DEAD    = 4,
  parameter int SS_STEP = 5
) (
  input  logic         clk,
  input  logic         rst,
  pwm_duty_gen_if.slave bus
);

  localparam int              CW       = $clog2(PERIOD);
  localparam logic [CW-1:0]   CNT_LAST = CW'(PERIOD - 1);
  localparam logic [11:0]     DUTY_MAX = 12'(PERIOD);
  localparam logic [3:0]      DT_FULL  = 4'(DEAD);

  // Catch parameter sets the datapath widths cannot represent.
  if (DEAD < 1 || DEAD > 15 || SS_STEP < 1 || PERIOD < 2 || PERIOD > 4095) begin : g_param_err
    $error("pwm_duty_gen: illegal PERIOD/DEAD/SS_STEP");
  end

  logic [CW-1:0] cnt, cnt_nxt;
  logic [11:0]   duty_act, duty_nxt;
  logic [11:0]   tgt;
  logic          en_q;
  logic          raw_q, raw_nxt;
  logic [3:0]    dt_cnt, dt_nxt;
  logic          pwm_hi_q, pwm_lo_q, period_start_q;
  logic          load;
  logic          edge_evt;
  logic          gate_ok;

  // Clamp the request to a full-on period.
  always_comb begin
    tgt = (bus.l_adj > DUTY_MAX) ? DUTY_MAX : bus.l_adj;
  end

  // Period restart: wrap, external sync, or the first enabled cycle.
  always_comb begin
    load    = bus.en && (bus.sync || !en_q || (cnt == CNT_LAST));
    cnt_nxt = cnt + 1'b1;
    if (!bus.en || load) cnt_nxt = '0;
  end

  // Shadow duty update, taken only at a period restart.
`ifdef SOFT_START_EN
  logic [12:0] ss_sum;
  always_comb begin
    ss_sum   = {1'b0, duty_act} + 13'(SS_STEP);
    duty_nxt = duty_act;
    if (!bus.en) begin
      duty_nxt = '0;
    end else if (load) begin
      if (tgt > duty_act)
        duty_nxt = (ss_sum > {1'b0, tgt}) ? tgt : ss_sum[11:0];
      else
        duty_nxt = tgt;
    end
  end
`else
  always_comb begin
    duty_nxt = duty_act;
    if (load) duty_nxt = tgt;
  end
`endif

  // Raw compare and dead-time sequencing; an enable rising edge counts as an
  // edge so the first period always opens with a full dead-time.
  always_comb begin
    raw_nxt  = bus.en && (12'(cnt) < duty_act);
    edge_evt = (raw_nxt != raw_q) || (bus.en && !en_q);
    if (!bus.en || edge_evt)
      dt_nxt = '0;
    else if (dt_cnt == DT_FULL)
      dt_nxt = DT_FULL;
    else
      dt_nxt = dt_cnt + 1'b1;
    gate_ok = bus.en && !edge_evt && (dt_nxt == DT_FULL);
  end

  // Counter, shadow register and enable history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      duty_act <= '0;
      en_q     <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      duty_act <= duty_nxt;
      en_q     <= bus.en;
    end
  end

  // Raw PWM, dead-time counter, registered gates and period strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q          <= 1'b0;
      dt_cnt         <= '0;
      pwm_hi_q       <= 1'b0;
      pwm_lo_q       <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      raw_q          <= raw_nxt;
      dt_cnt         <= dt_nxt;
      pwm_hi_q       <= gate_ok && raw_nxt;
      pwm_lo_q       <= gate_ok && !raw_nxt;
      period_start_q <= load;
    end
  end

  assign bus.pwm_hi       = pwm_hi_q;
  assign bus.pwm_lo       = pwm_lo_q;
  assign bus.period_start = period_start_q;
  assign bus.duty_act     = duty_act;

endmodule

// File: tb/tb_pwm_duty_gen.sv
// Randomized bench for pwm_duty_gen. The reference tracks where the period
// should restart, which duty must be in effect, and checks per-period gate
// on-times against closed-form widths plus overlap and dead-time rules.
module tb_pwm_duty_gen;
  localparam int PERIOD  = 500;
  localparam int DEAD    = 4;
  localparam int SS_STEP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_duty_gen_if ifc ();

  pwm_duty_gen #(.PERIOD(PERIOD), .DEAD(DEAD), .SS_STEP(SS_STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int failures = 0;

  // reference state
  int pos = 0;          // expected counter value this cycle
  bit was_en = 0;       // en seen at previous edge (out of reset)
  int exp_duty = 0;
  int win_d = -1;       // duty of the open period window
  int prev_d = -1;      // duty of the last full window, -1 if none
  int hi_cnt = 0, lo_cnt = 0;
  int low_run = 100;
  bit last_on = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_hi(int d);
    if (d == 0) return 0;
    if (d >= PERIOD) return PERIOD;
    return (d > DEAD) ? d - DEAD : 0;
  endfunction

  function automatic int exp_lo(int d);
    if (d >= PERIOD) return 0;
    if (d == 0) return PERIOD;
    return (PERIOD - d > DEAD) ? PERIOD - d - DEAD : 0;
  endfunction

  task automatic tick();
    bit en_e, s_e, r_e, ps_exp, wrap;
    int l_e, t;
    en_e = ifc.en; s_e = ifc.sync; r_e = rst; l_e = int'(ifc.l_adj);
    @(posedge clk); #2;
    if (r_e || rst) begin
      chk("rst_hi", ifc.pwm_hi, 0);
      chk("rst_lo", ifc.pwm_lo, 0);
      chk("rst_ps", ifc.period_start, 0);
      chk("rst_duty", int'(ifc.duty_act), 0);
      exp_duty = 0; was_en = 0; win_d = -1; prev_d = -1;
      low_run = 100; last_on = 0;
      return;
    end
    if (!en_e) begin
      chk("dis_hi", ifc.pwm_hi, 0);
      chk("dis_lo", ifc.pwm_lo, 0);
      chk("dis_ps", ifc.period_start, 0);
`ifdef SOFT_START_EN
      exp_duty = 0;
`endif
      was_en = 0; win_d = -1; prev_d = -1;
    end else begin
      wrap   = was_en && !s_e && (pos == PERIOD - 1);
      ps_exp = !was_en || s_e || (pos == PERIOD - 1);
      chk("period_start", ifc.period_start, ps_exp);
      if (ps_exp) begin
        if (wrap && win_d >= 0 && prev_d == win_d) begin
          chk("hi_width", hi_cnt, exp_hi(win_d));
          chk("lo_width", lo_cnt, exp_lo(win_d));
        end
        prev_d = (wrap && win_d >= 0) ? win_d : -1;
        t = (l_e > PERIOD) ? PERIOD : l_e;
`ifdef SOFT_START_EN
        if (t > exp_duty) exp_duty = (exp_duty + SS_STEP > t) ? t : exp_duty + SS_STEP;
        else exp_duty = t;
`else
        exp_duty = t;
`endif
        win_d = exp_duty; hi_cnt = 0; lo_cnt = 0; pos = 0;
      end else begin
        pos++;
      end
      was_en = 1;
    end
    chk("overlap", ifc.pwm_hi & ifc.pwm_lo, 0);
    chk("duty_act", int'(ifc.duty_act), exp_duty);
    hi_cnt += ifc.pwm_hi;
    lo_cnt += ifc.pwm_lo;
    if ((ifc.pwm_hi | ifc.pwm_lo) && !last_on)
      chk("deadtime", int'(low_run >= DEAD), 1);
    last_on = ifc.pwm_hi | ifc.pwm_lo;
    if (last_on) low_run = 0; else low_run++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_to_pos(input int p);
    int guard = 0;
    while (!(was_en && pos == p) && guard < 2 * PERIOD) begin
      tick(); guard++;
    end
    chk("reach_pos", int'(was_en && pos == p), 1);
  endtask

  task automatic sync_pulse();
    ifc.sync = 1'b1;
    tick();
    ifc.sync = 1'b0;
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #1;
    chk("async_hi", ifc.pwm_hi, 0);
    chk("async_lo", ifc.pwm_lo, 0);
    chk("async_ps", ifc.period_start, 0);
    chk("async_duty", int'(ifc.duty_act), 0);
    run(3);
    rst = 1'b0;
  endtask

  int vals[12] = '{0, 3, 4, 5, 100, 250, 495, 496, 497, 500, 600, 4095};

  initial begin
    ifc.en = 1'b0; ifc.sync = 1'b0; ifc.l_adj = '0;
    #1;
    chk("init_hi", ifc.pwm_hi, 0);
    chk("init_lo", ifc.pwm_lo, 0);
    chk("init_duty", int'(ifc.duty_act), 0);
    run(3);
    rst = 1'b0;
    run(5);

    // nominal 50 %
    ifc.l_adj = 12'd250; ifc.en = 1'b1;
    run(3 * PERIOD);
    // mid-period change is deferred to the next period
    run_to_pos(300);
    ifc.l_adj = 12'd100;
    run(3 * PERIOD);
    // clamp, zero and sub-dead-time duties
    ifc.l_adj = 12'd600; run(3 * PERIOD);
    ifc.l_adj = 12'd0;   run(3 * PERIOD);
    ifc.l_adj = 12'd3;   run(3 * PERIOD);
    // sync restarts the period and loads the new duty
    ifc.l_adj = 12'd250; run(2 * PERIOD);
    run_to_pos(200);
    ifc.l_adj = 12'd120;
    sync_pulse();
    run(3 * PERIOD);
    // asynchronous reset in the middle of a period
    run_to_pos(50);
    mid_reset();
    run(2 * PERIOD);

    // randomized phases
    for (int ph = 0; ph < 16; ph++) begin
      if ($urandom_range(0, 2) == 0) ifc.l_adj = 12'($urandom_range(0, 4095));
      else ifc.l_adj = 12'(vals[$urandom_range(0, 11)]);
      if ($urandom_range(0, 5) == 0) begin
        ifc.en = 1'b0;
        run($urandom_range(1, 20));
        ifc.en = 1'b1;
      end
      run(2 * PERIOD);
      if ($urandom_range(0, 3) == 0) begin
        run_to_pos($urandom_range(1, PERIOD - 2));
        ifc.l_adj = 12'($urandom_range(0, 700));
      end
      if ($urandom_range(0, 4) == 0) begin
        run($urandom_range(1, PERIOD - 1));
        sync_pulse();
      end
      run(PERIOD + $urandom_range(0, PERIOD));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
